// File: rtl/memory_island_pkg.sv
// Shared helpers for the memory island port logic.
// Holds the credit counter width function.
package memory_island_pkg;

  function automatic int unsigned cnt_width(
    input int unsigned depth
  );
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO with optional fall-through.
// Storage resets to zero so the read data starts at zero.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam int unsigned PtrW =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned UsgW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
  localparam logic [UsgW-1:0] FullUsg = UsgW'(DEPTH);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
  logic [PtrW-1:0] rd_q;
  logic [PtrW-1:0] wr_q;
  logic [UsgW-1:0] usg_q;
  logic [UsgW-1:0] usg_d;
  logic            empty_raw;
  logic            bypass;
  logic            do_push;
  logic            do_pop;

  assign empty_raw = (usg_q == '0);
  assign full_o    = (usg_q == FullUsg);
  assign bypass    = FALL_THROUGH & empty_raw & push_i;
  assign empty_o   = empty_raw & ~bypass;
  assign data_o    = bypass ? data_i : mem_q[rd_q];

  // A bypassed word consumed in the same cycle is never stored.
  assign do_push = push_i & ~full_o & ~(bypass & pop_i);
  assign do_pop  = pop_i & ~empty_raw;

  always_comb begin
    usg_d = usg_q;
    unique case (1'b1)
      do_push & ~do_pop: usg_d = usg_q + 1'b1;
      do_pop & ~do_push: usg_d = usg_q - 1'b1;
      default:           usg_d = usg_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      usg_q <= '0;
    end else begin
      usg_q <= usg_d;
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q <= (wr_q == LastPtr) ? '0 : wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= (rd_q == LastPtr) ? '0 : rd_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/memory_island_rsp_buffer_port.sv
// One port: credit counter, issue gating and response FIFO.
// Requests issue only while a buffer slot is free.
module memory_island_rsp_buffer_port
  import memory_island_pkg::*;
#(
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned Depth       = 4,
  parameter bit          FallThrough = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic                   we_i,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [DataWidth/8-1:0] strb_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DataWidth-1:0]   rsp_rdata_o,
  output logic                   mem_req_o,
  input  logic                   mem_gnt_i,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic                   mem_we_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  output logic [DataWidth/8-1:0] mem_strb_o,
  input  logic                   mem_rvalid_i,
  input  logic [DataWidth-1:0]   mem_rdata_i,
  output logic                   busy_o
);

  localparam int unsigned CntW = cnt_width(Depth);
  localparam logic [CntW-1:0] MaxCnt = CntW'(Depth);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;
  logic            inc;
  logic            dec;
  logic            push;
  logic            full;
  logic            empty;

  assign mem_req_o   = req_i & (cnt_q != MaxCnt);
  assign gnt_o       = mem_gnt_i & mem_req_o;
  assign mem_addr_o  = addr_i;
  assign mem_we_o    = we_i;
  assign mem_wdata_o = wdata_i;
  assign mem_strb_o  = strb_i;

  assign inc         = gnt_o;
  assign dec         = rsp_valid_o & rsp_ready_i;
  // Responses with no outstanding credit are dropped.
  assign push        = mem_rvalid_i & (cnt_q != '0);
  assign rsp_valid_o = ~empty;
  assign busy_o      = (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      inc & ~dec: cnt_d = cnt_q + 1'b1;
      dec & ~inc: cnt_d = cnt_q - 1'b1;
      default:    cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  fifo_v3 #(
    .FALL_THROUGH (FallThrough),
    .DATA_WIDTH   (DataWidth),
    .DEPTH        (Depth)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .full_o  (full),
    .empty_o (empty),
    .data_i  (mem_rdata_i),
    .push_i  (push),
    .data_o  (rsp_rdata_o),
    .pop_i   (dec)
  );

  rsp_without_credit: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    mem_rvalid_i |-> (cnt_q != '0));

  rvalid_not_full: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    mem_rvalid_i |-> !full);

  cnt_in_range: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    cnt_q <= MaxCnt);

  rsp_stable: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (rsp_valid_o & ~rsp_ready_i) |=>
      (rsp_valid_o & $stable(rsp_rdata_o)));

endmodule

// File: rtl/memory_island_rsp_buffer.sv
// Credit-limited response buffer for N memory island ports.
// Each port is an independent instance of the port block.
module memory_island_rsp_buffer
  import memory_island_pkg::*;
#(
  parameter int unsigned NumPorts    = 1,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned Depth       = 4,
  parameter bit          FallThrough = 1'b0
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NumPorts-1:0]                  req_i,
  output logic [NumPorts-1:0]                  gnt_o,
  input  logic [NumPorts-1:0][AddrWidth-1:0]   addr_i,
  input  logic [NumPorts-1:0]                  we_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]   wdata_i,
  input  logic [NumPorts-1:0][DataWidth/8-1:0] strb_i,
  output logic [NumPorts-1:0]                  rsp_valid_o,
  input  logic [NumPorts-1:0]                  rsp_ready_i,
  output logic [NumPorts-1:0][DataWidth-1:0]   rsp_rdata_o,
  output logic [NumPorts-1:0]                  mem_req_o,
  input  logic [NumPorts-1:0]                  mem_gnt_i,
  output logic [NumPorts-1:0][AddrWidth-1:0]   mem_addr_o,
  output logic [NumPorts-1:0]                  mem_we_o,
  output logic [NumPorts-1:0][DataWidth-1:0]   mem_wdata_o,
  output logic [NumPorts-1:0][DataWidth/8-1:0] mem_strb_o,
  input  logic [NumPorts-1:0]                  mem_rvalid_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]   mem_rdata_i,
  output logic [NumPorts-1:0]                  busy_o
);

  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    memory_island_rsp_buffer_port #(
      .AddrWidth   (AddrWidth),
      .DataWidth   (DataWidth),
      .Depth       (Depth),
      .FallThrough (FallThrough)
    ) i_port (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .req_i        (req_i[p]),
      .gnt_o        (gnt_o[p]),
      .addr_i       (addr_i[p]),
      .we_i         (we_i[p]),
      .wdata_i      (wdata_i[p]),
      .strb_i       (strb_i[p]),
      .rsp_valid_o  (rsp_valid_o[p]),
      .rsp_ready_i  (rsp_ready_i[p]),
      .rsp_rdata_o  (rsp_rdata_o[p]),
      .mem_req_o    (mem_req_o[p]),
      .mem_gnt_i    (mem_gnt_i[p]),
      .mem_addr_o   (mem_addr_o[p]),
      .mem_we_o     (mem_we_o[p]),
      .mem_wdata_o  (mem_wdata_o[p]),
      .mem_strb_o   (mem_strb_o[p]),
      .mem_rvalid_i (mem_rvalid_i[p]),
      .mem_rdata_i  (mem_rdata_i[p]),
      .busy_o       (busy_o[p])
    );
  end

endmodule
